// File: rtl/tinyalu_arbiter_pkg.sv
// Shared types for the TinyALU arbiter: ALU opcodes, arbiter FSM states and bus widths.
package tinyalu_arbiter_pkg;

  localparam int unsigned OperandW = 8;
  localparam int unsigned ResultW  = 16;
  localparam int unsigned OpW      = 3;

  typedef enum logic [OpW-1:0] {
    OpNoOp = 3'b000,
    OpAdd  = 3'b001,
    OpAnd  = 3'b010,
    OpXor  = 3'b011,
    OpMul  = 3'b100,
    OpRst  = 3'b111
  } operation_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle   = 2'd0;
  localparam arb_state_t StWait   = 2'd1;
  localparam arb_state_t StRstAlu = 2'd2;
  localparam arb_state_t StResp   = 2'd3;

  // Opcodes that occupy the ALU; 101/110 fall through as no_op.
  function automatic logic uses_alu(logic [OpW-1:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OpAdd, OpAnd, OpXor, OpMul: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/tinyalu_arbiter_if.sv
// Requester-side and ALU-side signals of the arbiter, bundled for connection at the top level.
interface tinyalu_arbiter_if
  import tinyalu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*OperandW-1:0] req_a;
  logic [NUM_REQ*OperandW-1:0] req_b;
  logic [NUM_REQ*OpW-1:0]      req_op;
  logic [NUM_REQ-1:0]          resp_valid;
  logic [ResultW-1:0]          resp_result;
  logic                        resp_err;

  logic                        alu_start;
  logic [OpW-1:0]              alu_op;
  logic [OperandW-1:0]         alu_a;
  logic [OperandW-1:0]         alu_b;
  logic                        alu_reset;
  logic                        alu_done;
  logic [ResultW-1:0]          alu_result;

  // Arbiter side.
  modport master (
    input  req, req_a, req_b, req_op, alu_done, alu_result,
    output resp_valid, resp_result, resp_err,
    output alu_start, alu_op, alu_a, alu_b, alu_reset
  );

  // Requesters plus the ALU.
  modport slave (
    output req, req_a, req_b, req_op, alu_done, alu_result,
    input  resp_valid, resp_result, resp_err,
    input  alu_start, alu_op, alu_a, alu_b, alu_reset
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_valid
);

  int unsigned cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    // Offset N lands back on 'last' itself, so it is only chosen when alone.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!grant_valid && req[IdxW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one TinyALU between NUM_REQ requesters: round-robin grant, held start, watchdog abort.
module tinyalu_arbiter
  import tinyalu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  tinyalu_arbiter_if.master bus
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);

  // Per-requester views of the packed operand buses.
  logic [OpW-1:0]      op_arr [NUM_REQ];
  logic [OperandW-1:0] a_arr  [NUM_REQ];
  logic [OperandW-1:0] b_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[OpW*g +: OpW];
    assign a_arr[g]  = bus.req_a[OperandW*g +: OperandW];
    assign b_arr[g]  = bus.req_b[OperandW*g +: OperandW];
  end

  logic [IdxW-1:0] grant_idx;
  logic            grant_valid;
  logic [IdxW-1:0] rr_last_q, rr_last_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req         (bus.req),
    .last        (rr_last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rst_pulse_q, rst_pulse_d;
  logic                alu_start_q, alu_start_d;
  logic [OpW-1:0]      alu_op_q, alu_op_d;
  logic [OperandW-1:0] alu_a_q, alu_a_d;
  logic [OperandW-1:0] alu_b_q, alu_b_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [ResultW-1:0]  resp_result_q, resp_result_d;
  logic                resp_err_q, resp_err_d;

  logic [OpW-1:0]      gnt_op;

  assign gnt_op = op_arr[grant_idx];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    rr_last_d     = rr_last_q;
    alu_start_d   = alu_start_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rst_pulse_d   = 1'b0;
    // Response fields live for exactly the one RESP cycle.
    resp_valid_d  = '0;
    resp_result_d = '0;
    resp_err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          idx_d = grant_idx;
          err_d = 1'b0;
          if (gnt_op == OpRst) begin
            rst_pulse_d = 1'b1;
            state_d     = StRstAlu;
          end else if (uses_alu(gnt_op)) begin
            alu_start_d = 1'b1;
            alu_op_d    = gnt_op;
            alu_a_d     = a_arr[grant_idx];
            alu_b_d     = b_arr[grant_idx];
            cnt_d       = '0;
            state_d     = StWait;
          end else begin
            resp_valid_d[grant_idx] = 1'b1;
            state_d                 = StResp;
          end
        end
      end

      StWait: begin
        // A done arriving on the timeout cycle still completes normally.
        if (bus.alu_done) begin
          alu_start_d         = 1'b0;
          resp_valid_d[idx_q] = 1'b1;
          resp_result_d       = bus.alu_result;
          state_d             = StResp;
        end else if (cnt_q == CntLast) begin
          alu_start_d = 1'b0;
          rst_pulse_d = 1'b1;
          err_d       = 1'b1;
          state_d     = StRstAlu;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRstAlu: begin
        resp_valid_d[idx_q] = 1'b1;
        resp_err_d          = err_q;
        state_d             = StResp;
      end

      StResp: begin
        rr_last_d = idx_q;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      rr_last_q     <= IdxW'(NUM_REQ - 1);
      rst_pulse_q   <= 1'b0;
      alu_start_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      rr_last_q     <= rr_last_d;
      rst_pulse_q   <= rst_pulse_d;
      alu_start_q   <= alu_start_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign bus.alu_start   = alu_start_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  // Chip reset must reach the ALU without waiting a cycle.
  assign bus.alu_reset   = reset | rst_pulse_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with an ALU stub and a response scoreboard.
module tb_tinyalu_arbiter;
  import tinyalu_arbiter_pkg::*;

  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 15;

  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] result;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  tinyalu_arbiter_if #(.NUM_REQ(NReq)) bus ();

  tinyalu_arbiter #(
    .NUM_REQ (NReq),
    .TIMEOUT (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: done after done_delay cycles of start, never when hung.
  logic       hang;
  logic [7:0] done_delay;
  logic [7:0] start_cnt;

  function automatic logic [15:0] alu_model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset || !bus.alu_start) start_cnt <= 8'd0;
    else                         start_cnt <= start_cnt + 8'd1;
  end

  assign bus.alu_done   = bus.alu_start && !hang && (start_cnt == done_delay - 8'd1);
  assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  exp_t       exp_q[$];
  logic [3:0] again, rearm1, rearm2;
  logic [7:0] again_a, again_b;
  logic [2:0] again_op;

  int          s_start, s_rst, s_lat, s_unstable;
  logic [18:0] s_cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] res, input logic err,
                       input bit push);
    exp_t e;
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
    bus.req              = bus.req | (4'b0001 << i);
    if (push) begin
      e.valid  = 4'b0001 << i;
      e.result = res;
      e.err    = err;
      exp_q.push_back(e);
    end
  endtask

  // Runs until every expected response is seen, collecting ALU-side statistics.
  task automatic serve(input int max_cycles);
    int   n;
    logic run;
    logic first;
    exp_t e;
    n = 0; run = 1'b0; first = 1'b1;
    s_start = 0; s_rst = 0; s_lat = -1; s_unstable = 0; s_cap = '0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (rearm1[0]) begin
        bus.req_op[2:0] = again_op;
        bus.req_a[7:0]  = again_a;
        bus.req_b[7:0]  = again_b;
      end
      bus.req = bus.req | rearm1;
      rearm1  = rearm2;
      rearm2  = '0;
      if (bus.alu_start) begin
        s_start++;
        if (!run && first) begin
          s_cap = {bus.alu_op, bus.alu_a, bus.alu_b};
          first = 1'b0;
        end else if (run && ({bus.alu_op, bus.alu_a, bus.alu_b} != s_cap)) begin
          s_unstable++;
        end
      end
      run = bus.alu_start;
      if (bus.alu_reset) s_rst++;
      if (bus.resp_valid != '0) begin
        if (s_lat < 0) s_lat = n;
        e = exp_q.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 32'(e.valid));
        chk("resp_result", 32'(bus.resp_result), 32'(e.result));
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        bus.req = bus.req & ~bus.resp_valid;
        rearm2  = bus.resp_valid & again;
        again   = again & ~bus.resp_valid;
      end
    end
    chk("serve_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    hang = 1'b0; done_delay = 8'd2;
    again = '0; rearm1 = '0; rearm2 = '0;
    again_a = 8'h3C; again_b = 8'h0F; again_op = 3'b011;

    repeat (3) @(negedge clk);
    chk("reset_alu_reset", 32'(bus.alu_reset), 32'd1);
    chk("reset_outs_a", 32'({bus.alu_start, bus.resp_valid, bus.resp_err, bus.alu_op,
                             bus.alu_a, bus.alu_b}), 32'd0);
    chk("reset_result", 32'(bus.resp_result), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_alu_reset", 32'(bus.alu_reset), 32'd0);

    // Single add on requester 0.
    done_delay = 8'd2;
    issue(0, 3'b001, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b1);
    serve(30);
    chk("add_latency", 32'(s_lat), 32'd3);
    chk("add_start_cycles", 32'(s_start), 32'd2);
    chk("add_operands", 32'(s_cap), 32'({3'b001, 8'h12, 8'h34}));
    chk("add_stable", 32'(s_unstable), 32'd0);

    // mul FF*FF on requester 2 with a 3-cycle ALU.
    repeat (2) @(negedge clk);
    done_delay = 8'd3;
    issue(2, 3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1);
    serve(30);
    chk("mul_latency", 32'(s_lat), 32'd4);
    chk("mul_start_cycles", 32'(s_start), 32'd3);
    chk("mul_stable", 32'(s_unstable), 32'd0);

    // no_op, then the 101 alias, complete locally.
    repeat (2) @(negedge clk);
    issue(1, 3'b000, 8'h55, 8'hAA, 16'h0000, 1'b0, 1'b1);
    serve(20);
    chk("noop_latency", 32'(s_lat), 32'd1);
    chk("noop_no_start", 32'(s_start), 32'd0);
    repeat (2) @(negedge clk);
    issue(0, 3'b101, 8'h01, 8'h02, 16'h0000, 1'b0, 1'b1);
    serve(20);
    chk("op101_no_start", 32'(s_start), 32'd0);

    // rst_op pulses the ALU reset for exactly one cycle.
    repeat (2) @(negedge clk);
    issue(3, 3'b111, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
    serve(20);
    chk("rstop_latency", 32'(s_lat), 32'd2);
    chk("rstop_pulse", 32'(s_rst), 32'd1);
    chk("rstop_no_start", 32'(s_start), 32'd0);

    // Round-robin: last served was 3, so 0,1,2,3 then 0 again.
    repeat (2) @(negedge clk);
    done_delay = 8'd1;
    again = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a, b;
      a = 8'(8'h10 * i + 1);
      b = 8'hA5 ^ 8'(i);
      issue(i, 3'b011, a, b, {8'h00, a ^ b}, 1'b0, 1'b1);
    end
    exp_q.push_back('{valid: 4'b0001, result: {8'h00, 8'h3C ^ 8'h0F}, err: 1'b0});
    serve(80);

    // Watchdog: ALU never answers.
    repeat (2) @(negedge clk);
    hang = 1'b1;
    issue(1, 3'b001, 8'h01, 8'h02, 16'h0000, 1'b1, 1'b1);
    serve(40);
    chk("tmo_latency", 32'(s_lat), 32'd17);
    chk("tmo_start_cycles", 32'(s_start), 32'd15);
    chk("tmo_rst_pulse", 32'(s_rst), 32'd1);
    hang = 1'b0;

    // Reset in the middle of a long mul abandons it.
    repeat (2) @(negedge clk);
    done_delay = 8'd20;
    issue(2, 3'b100, 8'h0A, 8'h0B, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_mul_start", 32'(bus.alu_start), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 32'({bus.alu_start, bus.resp_valid, bus.resp_err, bus.alu_op,
                            bus.alu_a, bus.alu_b}), 32'd0);
    chk("midrst_alu_reset", 32'(bus.alu_reset), 32'd1);
    reset   = 1'b0;
    bus.req = '0;
    seen    = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    done_delay = 8'd2;
    issue(0, 3'b001, 8'h02, 8'h02, 16'h0004, 1'b0, 1'b1);
    issue(2, 3'b001, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b1);
    serve(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
